// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one imem request at a time, holds the returned word for IF/ID.
// Optional FETCH_PERF_EN adds fetch_cnt / kill_cnt performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF,
  output logic        busyF
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] kill_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_kill, w_kill_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_buf;
  logic        w_buf_we;
  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign PCF        = r_pc;
  assign imem_addr  = r_pc;
  assign PCPlus4F   = w_pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  // A redirect overrides en everywhere; a response racing a redirect is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_kill_nxt  = r_kill;
    w_pc_nxt    = r_pc;
    w_buf_we    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (imem_ready) begin
          w_state_nxt = S_WAIT;
          if (PCSrcE) w_kill_nxt = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (!r_kill && !PCSrcE) begin
            w_state_nxt = S_HOLD;
            w_buf_we    = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
          w_kill_nxt = 1'b0;
        end else if (PCSrcE) begin
          w_kill_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          w_state_nxt = S_REQ;
        end else if (en) begin
          w_state_nxt = S_REQ;
          w_pc_nxt    = w_pc_plus4;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
    if (PCSrcE) w_pc_nxt = PCTargetE;
  end

  always_comb begin
    imem_req = 1'b0;
    validF   = 1'b0;
    instrF   = NOP_INSTR;
    case (r_state)
      S_REQ:  imem_req = 1'b1;
      S_HOLD: begin
        validF = 1'b1;
        instrF = r_buf;
      end
      default: ;
    endcase
    busyF = !validF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_kill <= 1'b0;
      r_buf  <= NOP_INSTR;
    end else begin
      r_pc   <= w_pc_nxt;
      r_kill <= w_kill_nxt;
      if (w_buf_we) r_buf <= imem_rdata;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_cnt, r_kill_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
      r_kill_cnt  <= 32'd0;
    end else begin
      if (r_state == S_HOLD && en && !PCSrcE)
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (r_state == S_WAIT && imem_rvalid && (r_kill || PCSrcE))
        r_kill_cnt <= r_kill_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign kill_cnt  = r_kill_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// transaction-level model (outstanding-request queue with stale flags).
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, PCSrcE = 1'b0, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] PCTargetE = '0, imem_rdata = '0;
  logic        imem_req, validF, busyF;
  logic [31:0] imem_addr, instrF, PCF, PCPlus4F;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, kill_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .en(en), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instrF(instrF),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .validF(validF), .busyF(busyF)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .kill_cnt(kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: PC, held word, and a queue of accepted requests tagged stale/live.
  logic [31:0] m_pc, m_word, m_fetch, m_kill;
  bit          m_have;
  bit          m_q[$];

  function automatic void model_reset();
    m_pc = 32'h0; m_word = NOP; m_have = 0; m_q.delete();
    m_fetch = 0; m_kill = 0;
  endfunction

  function automatic void model_step();
    bit asking;
    bit stale;
    asking = (m_q.size() == 0) && !m_have;
    if (m_have) begin
      if (PCSrcE) m_have = 0;
      else if (en) begin m_have = 0; m_pc = m_pc + 32'd4; m_fetch = m_fetch + 1; end
    end else if (asking) begin
      if (imem_ready) m_q.push_back(PCSrcE);
    end else if (imem_rvalid) begin
      stale = m_q.pop_front();
      if (!stale && !PCSrcE) begin m_have = 1; m_word = imem_rdata; end
      else m_kill = m_kill + 1;
    end else if (PCSrcE) begin
      m_q[0] = 1;
    end
    if (PCSrcE) m_pc = PCTargetE;
  endfunction

  task automatic cyc(input logic e, input logic p, input logic [31:0] t,
                     input logic rdy, input logic rv, input logic [31:0] rd);
    en = e; PCSrcE = p; PCTargetE = t; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instrF !== NOP ||
        validF !== 1'b0 || busyF !== 1'b1 || PCF !== 32'h0) begin
      n_fail++;
      $display("FAIL reset: req=%b addr=%h instr=%h valid=%b busy=%b, required 1 0 %h 0 1",
               imem_req, imem_addr, instrF, validF, busyF, NOP);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_fetch();
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = 32'(k * 4);
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        n_fail++; $display("FAIL basic_req: req=%b addr=%h, required 1 %h", imem_req, imem_addr, a);
      end
      cyc(1, 0, 0, 1, 0, 0);
      n_chk++;
      if (imem_req !== 1'b0 || validF !== 1'b0) begin
        n_fail++; $display("FAIL basic_wait: req=%b valid=%b, required 0 0", imem_req, validF);
      end
      cyc(1, 0, 0, 0, 1, a ^ PAT);
      n_chk++;
      if (validF !== 1'b1 || busyF !== 1'b0 || instrF !== (a ^ PAT) || PCF !== a ||
          PCPlus4F !== a + 32'd4) begin
        n_fail++;
        $display("FAIL basic_hold: valid=%b instr=%h pc=%h pc4=%h, required 1 %h %h %h",
                 validF, instrF, PCF, PCPlus4F, a ^ PAT, a, a + 32'd4);
      end
      if (k < 2) cyc(1, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      n_chk++;
      if (PCF !== 32'h8 || instrF !== (32'h8 ^ PAT) || imem_req !== 1'b0 || validF !== 1'b1) begin
        n_fail++;
        $display("FAIL stall: pc=%h instr=%h req=%b valid=%b, required 8 %h 0 1",
                 PCF, instrF, imem_req, validF, 32'h8 ^ PAT);
      end
    end
    cyc(1, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      n_fail++; $display("FAIL stall_release: req=%b addr=%h, required 1 c", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'hC ^ PAT);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 32'h100, 0, 0, 0);
    n_chk++;
    if (validF !== 1'b0 || imem_req !== 1'b0 || PCF !== 32'h100) begin
      n_fail++; $display("FAIL redir_wait_a: valid=%b req=%b pc=%h, required 0 0 100", validF, imem_req, PCF);
    end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h10 ^ PAT);
    n_chk++;
    if (validF !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_wait_drop: valid=%b req=%b addr=%h, required 0 1 100", validF, imem_req, imem_addr);
    end
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h100 ^ PAT);
    n_chk++;
    if (validF !== 1'b1 || instrF !== (32'h100 ^ PAT) || PCF !== 32'h100) begin
      n_fail++;
      $display("FAIL redir_wait_hold: valid=%b instr=%h pc=%h, required 1 %h 100", validF, instrF, PCF, 32'h100 ^ PAT);
    end
  endtask

  task automatic test_redirect_vs_stall();
    cyc(0, 1, 32'h200, 0, 0, 0);
    n_chk++;
    if (validF !== 1'b0 || PCF !== 32'h200 || imem_req !== 1'b1 || instrF !== NOP) begin
      n_fail++;
      $display("FAIL redir_stall: valid=%b pc=%h req=%b instr=%h, required 0 200 1 %h", validF, PCF, imem_req, instrF, NOP);
    end
  endtask

  task automatic test_reset_mid_wait();
    cyc(1, 0, 0, 1, 0, 0);
    imem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (PCF !== 32'h0 || imem_addr !== 32'h0 || validF !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async: pc=%h addr=%h valid=%b req=%b, required 0 0 0 1", PCF, imem_addr, validF, imem_req);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc(1, 0, 0, 0, 1, 32'hDEADBEEF);
    n_chk++;
    if (PCF !== 32'h0 || imem_addr !== 32'h0 || validF !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_late_rvalid: pc=%h addr=%h valid=%b req=%b, required 0 0 0 1", PCF, imem_addr, validF, imem_req);
    end
  endtask

  task automatic test_wrap();
    cyc(1, 1, 32'hFFFFFFFC, 0, 0, 0);
    n_chk++;
    if (PCF !== 32'hFFFFFFFC || PCPlus4F !== 32'h0) begin
      n_fail++; $display("FAIL wrap_pc4: pc=%h pc4=%h, required fffffffc 0", PCF, PCPlus4F);
    end
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'hFFFFFFFC ^ PAT);
    cyc(1, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_next: req=%b addr=%h, required 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_instr;
    bit          exp_req;
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) != 0, ($urandom % 6) == 0, $urandom,
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      exp_req   = (m_q.size() == 0) && !m_have;
      exp_instr = m_have ? m_word : NOP;
      n_chk++;
      if (imem_req !== exp_req || validF !== m_have || busyF !== !m_have || instrF !== exp_instr ||
          PCF !== m_pc || imem_addr !== m_pc || PCPlus4F !== m_pc + 32'd4) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%b valid=%b instr=%h pc=%h pc4=%h, required %b %b %h %h %h",
                 i, imem_req, validF, instrF, PCF, PCPlus4F, exp_req, m_have, exp_instr, m_pc, m_pc + 32'd4);
      end
`ifdef FETCH_PERF_EN
      n_chk++;
      if (fetch_cnt !== m_fetch || kill_cnt !== m_kill) begin
        n_fail++;
        $display("FAIL perf[%0d]: fetch=%0d kill=%0d, required %0d %0d", i, fetch_cnt, kill_cnt, m_fetch, m_kill);
      end
`endif
    end
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_vs_stall();
    test_reset_mid_wait();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
